// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, default halt opcode and the prefetch FIFO entry type.
package fetch_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] DEFAULT_HALT_OPCODE = 8'hFF;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/imem_fetch_if.sv
// imem_fetch_if: memory read port, decoder handshake and redirect bundle around the fetch unit.
interface imem_fetch_if;
  import fetch_pkg::*;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  modport master (
    output imem_addr, instr_valid, instr_data, instr_pc,
    input  imem_data, instr_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_addr, instr_valid, instr_data, instr_pc,
    output imem_data, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries; flush clears it, head reads 0 when empty.
module fetch_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [AW:0]  count
);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  assign do_push = push && !flush;
  assign do_pop  = pop && count_q != '0 && !flush;
  assign count   = count_q;
  assign head    = count_q != '0 ? mem_q[rd_q] : '0;
  always_comb begin
    wr_d    = flush ? '0 : wr_q + AW'(do_push);
    rd_d    = flush ? '0 : rd_q + AW'(do_pop);
    count_d = flush ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata;
endmodule

// File: rtl/imem_fetch.sv
// imem_fetch: PC walker with one-deep read tracking, credit-gated issue and prefetch FIFO.
// Optional halt-on-opcode stop enabled by defining FETCH_HALT_EN.
module imem_fetch import fetch_pkg::*; #(
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
`ifdef FETCH_HALT_EN
  , parameter logic [DATA_W-1:0] HALT_OPCODE = DEFAULT_HALT_OPCODE
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic fetch_en,
  output logic halted,
  imem_fetch_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d;
  logic inflight_q, inflight_d;
  logic redirect, pop, push, issue, stop;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  fetch_entry_t head, wdata;
  assign redirect         = bus.redirect_valid;
  assign bus.imem_addr    = fetch_pc_q;
  assign bus.instr_valid  = count != '0;
  assign bus.instr_data   = head.instr;
  assign bus.instr_pc     = head.pc;
  assign pop   = bus.instr_valid && bus.instr_ready;
  assign push  = inflight_q && !redirect && !stop;
  assign wdata = {inflight_pc_q, bus.imem_data};
  // occupancy the FIFO will reach once the outstanding read lands
  assign occ   = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue = fetch_en && !redirect && !stop && occ < (CW+1)'(DEPTH);
  always_comb begin
    fetch_pc_d    = redirect ? bus.redirect_pc : issue ? fetch_pc_q + 8'd1 : fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end
`ifdef FETCH_HALT_EN
  logic halt_seen_q, halt_seen_d, halted_q, halted_d;
  // halt_seen stops issue and drops late responses; halted reports once decode consumes the byte
  always_comb begin
    halt_seen_d = redirect ? 1'b0 : halt_seen_q || (push && bus.imem_data == HALT_OPCODE);
    halted_d    = redirect ? 1'b0 : halted_q || (pop && head.instr == HALT_OPCODE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      halt_seen_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      halt_seen_q <= halt_seen_d;
      halted_q    <= halted_d;
    end
  end
  assign stop   = halt_seen_q;
  assign halted = halted_q;
`else
  assign stop   = 1'b0;
  assign halted = 1'b0;
`endif
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );
endmodule
